// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared definitions for the memory access unit. Holds the RV32I
//           load/store size codes, the controller state type and a
//           helper that classifies legal size codes.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  // RV32I funct3 size codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // True for the five size codes a load may carry
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_if
// Purpose : Bundles the core request/response handshake and the word memory
//           bus of the memory access unit.
// Ports   : none; signals
//           req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (request)
//           rsp_valid/rsp_rdata/rsp_error                            (response)
//           mem_address/mem_write_data/mem_write_enable/mem_read_data (memory)
//           modport slave  : view of the memory access unit
//           modport master : view of the environment (core + memory)
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_write_data, mem_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_byte_lane.sv
`default_nettype none
// ============================================================================
// Module  : mem_byte_lane
// Purpose : Combinational lane logic. Extracts and extends the addressed
//           byte/halfword of a memory word for loads, and merges store data
//           into the addressed lane for sub-word read-modify-write.
// Ports   : i_word       - word read from memory
//           i_byte_off   - byte offset within the word (addr[1:0])
//           i_funct3     - RV32I size code
//           i_wdata      - low 16 bits of right-justified store data
//           o_load_data  - extended load result
//           o_store_word - i_word with the selected lane replaced
// Revision: 1.0 - initial release
// ============================================================================
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian: byte offset n lives in bits [8n+7:8n]
  assign w_byte = i_word[{i_byte_off, 3'b000} +: 8];
  assign w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B: o_store_word[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_byte_off[1]) o_store_word[31:16] = i_wdata;
        else               o_store_word[15:0]  = i_wdata;
      end
      default: o_store_word = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Purpose : Initiator side of a single-port word memory. Accepts one
//           load/store at a time, issues word-aligned memory cycles, extends
//           sub-word loads and performs sub-word stores as read-modify-write.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           bus     - mem_access_unit_if.slave (request, response, memory bus)
// Params  : MEM_WORDS - memory depth in 32-bit words
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_access_unit_if.slave    bus
);

  localparam logic [31:0] C_ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_byte_off;
  logic [15:0] r_wdata_lo;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic        r_mem_write_enable;

  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_bad_store;
  logic        w_req_error;
  logic        w_is_sw;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  // Request classification, evaluated on the raw request in IDLE
  assign w_misaligned   = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0])
                        || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
  assign w_out_of_range = (bus.req_addr >= C_ADDR_LIMIT);
  // Unsigned size codes have no store counterpart
  assign w_bad_store    = bus.req_we && ((bus.req_funct3 == F3_BU) || (bus.req_funct3 == F3_HU));
  assign w_req_error    = !f3_is_legal(bus.req_funct3) || w_misaligned || w_out_of_range || w_bad_store;
  assign w_is_sw        = bus.req_we && (bus.req_funct3 == F3_W);

  mem_byte_lane u_lane (
    .i_word       (bus.mem_read_data),
    .i_byte_off   (r_byte_off),
    .i_funct3     (r_funct3),
    .i_wdata      (r_wdata_lo),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_we               <= 1'b0;
      r_funct3           <= 3'b000;
      r_byte_off         <= 2'b00;
      r_wdata_lo         <= 16'h0;
      r_rsp_valid        <= 1'b0;
      r_rsp_rdata        <= 32'h0;
      r_rsp_error        <= 1'b0;
      r_mem_address      <= 32'h0;
      r_mem_write_data   <= 32'h0;
      r_mem_write_enable <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_funct3   <= bus.req_funct3;
            r_byte_off <= bus.req_addr[1:0];
            r_wdata_lo <= bus.req_wdata[15:0];
            if (w_req_error) begin
              // Rejected requests never touch the memory bus
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_state     <= RESP;
            end else begin
              r_mem_address <= {bus.req_addr[31:2], 2'b00};
              if (w_is_sw) begin
                // Whole-word store needs no read; write straight away
                r_mem_write_data   <= bus.req_wdata;
                r_mem_write_enable <= 1'b1;
                r_state            <= WR;
              end else begin
                r_state <= RD;
              end
            end
          end
        end
        RD: begin
          // Address is on the bus this cycle; data appears during CAP
          r_state <= CAP;
        end
        CAP: begin
          if (r_we) begin
            r_mem_write_data   <= w_store_word;
            r_mem_write_enable <= 1'b1;
            r_state            <= WR;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= w_load_data;
            r_state     <= RESP;
          end
        end
        WR: begin
          r_mem_write_enable <= 1'b0;
          r_rsp_valid        <= 1'b1;
          r_rsp_error        <= 1'b0;
          r_rsp_rdata        <= 32'h0;
          r_state            <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_write_enable <= 1'b0;
          r_rsp_valid        <= 1'b0;
          r_state            <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = (r_state == IDLE);
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_rdata        = r_rsp_rdata;
  assign bus.rsp_error        = r_rsp_error;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_write_data   = r_mem_write_data;
  assign bus.mem_write_enable = r_mem_write_enable;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Self-checking bench for mem_access_unit. A reference model
//           predicts responses and memory writes into queues; an independent
//           monitor pops and compares whenever the unit responds or writes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int LIMIT     = MEM_WORDS * 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int due; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  function automatic logic [31:0] init_word(int i);
    if (i == 32'h40) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word memory: registered read, write on strobe
  initial begin
    int idx;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
    bus.mem_read_data = 32'h0;
    forever begin
      @(posedge clk);
      idx = int'(bus.mem_address >> 2);
      if (bus.mem_address < 32'(LIMIT)) begin
        if (bus.mem_write_enable) mem[idx] = bus.mem_write_data;
        bus.mem_read_data <= mem[idx];
      end else begin
        bus.mem_read_data <= 32'h0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.rsp_valid) begin
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected actual=1 required=0 (t=%0t)", $time);
          end else begin
            r = rq.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, r.rdata);
            chk("rsp_error", 32'(bus.rsp_error), 32'(r.err));
            chk("rsp_cycle", 32'(cyc), 32'(r.due));
          end
        end
        if (bus.mem_write_enable) begin
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected actual=1 required=0 addr=%h (t=%0t)", bus.mem_address, $time);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", bus.mem_address, w.addr);
            chk("wr_data", bus.mem_write_data, w.data);
            chk("wr_cycle", 32'(cyc), 32'(w.due));
          end
        end
      end
    end
  end

  // Reference model: predicts one request from the architectural rules.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int acc);
    logic        err;
    int          idx, off;
    logic [31:0] word, sh, mask, v;
    rsp_t        r;
    wr_t         w;
    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
        || ((f3 == 3'd1 || f3 == 3'd5) && addr[0])
        || (f3 == 3'd2 && addr[1:0] != 2'b00)
        || (addr >= 32'(LIMIT))
        || (we && f3[2]);
    r.err = err; r.rdata = 32'h0;
    if (err) begin
      r.due = acc;
    end else begin
      idx  = int'(addr / 4);
      off  = int'(addr % 4);
      word = ref_mem[idx];
      if (we) begin
        if (f3 == 3'd2) begin
          v = wdata; r.due = acc + 1; w.due = acc;
        end else begin
          mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
          v = (word & ~mask) | ((wdata << (8 * off)) & mask);
          r.due = acc + 3; w.due = acc + 2;
        end
        ref_mem[idx] = v;
        w.addr = addr & 32'hFFFFFFFC;
        w.data = v;
        wq.push_back(w);
      end else begin
        sh = word >> (8 * off);
        case (f3)
          3'd0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
          3'd1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
          3'd4: v = sh & 32'hFF;
          3'd5: v = sh & 32'hFFFF;
          default: v = word;
        endcase
        r.rdata = v;
        r.due = acc + 2;
      end
    end
    rq.push_back(r);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout actual=0 required=1 (t=%0t)", $time);
      return;
    end
    predict(we, f3, addr, wdata, cyc + 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int          rsp_seen, wr_seen, n;
    logic [31:0] a;
    logic [2:0]  f;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    issue(1'b0, F3_B,  32'h101, 32'h0);
    issue(1'b0, F3_HU, 32'h102, 32'h0);
    issue(1'b0, F3_H,  32'h100, 32'h0);
    issue(1'b1, F3_B,  32'h103, 32'h1234565A);
    issue(1'b0, F3_W,  32'h100, 32'h0);
    issue(1'b1, F3_W,  32'h104, 32'hDEADBEEF);
    issue(1'b0, F3_W,  32'h104, 32'h0);
    issue(1'b0, F3_W,  32'h102, 32'h0);
    issue(1'b0, F3_B,  32'(LIMIT), 32'h0);
    issue(1'b1, F3_BU, 32'h108, 32'h11223344);
    issue(1'b0, 3'b011, 32'h108, 32'h0);
    issue(1'b0, F3_BU, 32'(LIMIT - 1), 32'h0);
    // Hard-coded expectations for the preloaded word after the SB
    chk("ref_sb_merge", ref_mem[32'h40], 32'h5A99AABB);

    // Abort a sub-word store during CAP with reset
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);              // accept -> RD
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);              // -> CAP
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_we_in_reset", 32'(bus.mem_write_enable), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    rsp_seen = 0; wr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) rsp_seen++;
      if (bus.mem_write_enable) wr_seen++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
    chk("abort_no_write", 32'(wr_seen), 32'd0);
    chk("abort_mem_kept", mem[32'h40], 32'h5A99AABB);
    issue(1'b0, F3_W, 32'h100, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      if (f == 3'd3 && $urandom_range(0, 3) != 0) f = F3_W;
      case ($urandom_range(0, 9))
        0:       a = 32'(LIMIT) + 32'($urandom_range(0, 15));
        1:       a = $urandom;
        default: a = 32'h100 + 32'($urandom_range(0, 127));
      endcase
      issue(1'($urandom_range(0, 1)), f, a, $urandom);
    end

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", rq.size() + wq.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
